// File: rtl/adbg_or1k_spr_bridge.sv
// ============================================================================
// Module   : adbg_or1k_spr_bridge
// Brief    : Per-core debug SPR request stage with ack timeout watchdog.
//            Optional macro ADBG_SPR_STALL_GATE_EN gates the SPR strobe on cpu_stalled_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adbg_or1k_spr_bridge #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rstn_i,
    input  logic [15:0] dbg_addr_i,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_we_i,
    input  logic        dbg_stb_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_data_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_data_o,
    output logic        spr_we_o,
    output logic        spr_stb_o,
    input  logic [31:0] spr_data_i,
    input  logic        spr_ack_i,
    input  logic        cpu_stalled_i,
    input  logic        err_clr_i,
    output logic        timeout_err_o
);

    localparam int                c_CNT_W   = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_RESP     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_stb_en;
    logic                 w_ack_ok;

`ifdef ADBG_SPR_STALL_GATE_EN
    // The core only sees the strobe (and may only ack) while halted by debug.
    assign w_stb_en = cpu_stalled_i;
    assign w_ack_ok = spr_ack_i & spr_stb_o & cpu_stalled_i;
`else
    logic w_unused_stall;
    assign w_unused_stall = cpu_stalled_i;
    assign w_stb_en       = 1'b1;
    assign w_ack_ok       = spr_ack_i;
`endif

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            dbg_ack_o     <= 1'b0;
            dbg_data_o    <= '0;
            spr_addr_o    <= '0;
            spr_data_o    <= '0;
            spr_we_o      <= 1'b0;
            spr_stb_o     <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            dbg_ack_o <= 1'b0;
            if (err_clr_i) begin
                timeout_err_o <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (dbg_stb_i) begin
                        spr_addr_o <= dbg_addr_i;
                        spr_data_o <= dbg_data_i;
                        spr_we_o   <= dbg_we_i;
                        spr_stb_o  <= w_stb_en;
                        r_cnt      <= '0;
                        r_state    <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (w_ack_ok) begin
                        spr_stb_o <= 1'b0;
                        if (!spr_we_o) begin
                            dbg_data_o <= spr_data_i;
                        end
                        dbg_ack_o <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (r_cnt == c_CNT_MAX) begin
                        // Watchdog expiry: later assignment beats a same-cycle clear.
                        spr_stb_o <= 1'b0;
                        if (!spr_we_o) begin
                            dbg_data_o <= ERR_DATA;
                        end
                        timeout_err_o <= 1'b1;
                        dbg_ack_o     <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt     <= r_cnt + c_CNT_W'(1);
                        spr_stb_o <= w_stb_en;
                    end
                end

                S_RESP: begin
                    r_state <= S_WAIT_LOW;
                end

                S_WAIT_LOW: begin
                    if (!dbg_stb_i) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adbg_or1k_spr_bridge.sv
// ============================================================================
// Module   : tb_adbg_or1k_spr_bridge
// Brief    : Scoreboard bench for adbg_or1k_spr_bridge with TIMEOUT=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adbg_or1k_spr_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] dbg_addr_i = '0;
    logic [31:0] dbg_data_i = '0;
    logic        dbg_we_i = 1'b0;
    logic        dbg_stb_i = 1'b0;
    logic        dbg_ack_o;
    logic [31:0] dbg_data_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_data_o;
    logic        spr_we_o;
    logic        spr_stb_o;
    logic [31:0] spr_data_i = '0;
    logic        spr_ack_i = 1'b0;
    logic        cpu_stalled_i = 1'b1;
    logic        err_clr_i = 1'b0;
    logic        timeout_err_o;

    adbg_or1k_spr_bridge #(.TIMEOUT(T), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .cpu_clk_i     (clk),
        .cpu_rstn_i    (rstn),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_data_i    (dbg_data_i),
        .dbg_we_i      (dbg_we_i),
        .dbg_stb_i     (dbg_stb_i),
        .dbg_ack_o     (dbg_ack_o),
        .dbg_data_o    (dbg_data_o),
        .spr_addr_o    (spr_addr_o),
        .spr_data_o    (spr_data_o),
        .spr_we_o      (spr_we_o),
        .spr_stb_o     (spr_stb_o),
        .spr_data_i    (spr_data_i),
        .spr_ack_i     (spr_ack_i),
        .cpu_stalled_i (cpu_stalled_i),
        .err_clr_i     (err_clr_i),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_total = 0;
    int          stb_cnt = 0;
    int          core_delay = -1;
    logic [31:0] core_data = '0;
    logic [32:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Core model: acks in stb cycle number core_delay (0 = first), never if negative.
    always @(negedge clk) begin
        spr_ack_i = 1'b0;
        if (spr_stb_o) begin
            if (stb_cnt == core_delay) begin
                spr_ack_i  = 1'b1;
                spr_data_i = core_data;
            end
            stb_cnt++;
        end
    end

    // Monitor: every ack pops one expected {err, data} entry.
    always @(negedge clk) begin
        logic [32:0] e;
        if (dbg_ack_o) begin
            ack_total++;
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ack_data", dbg_data_o, e[31:0]);
                chk("ack_err", {31'd0, timeout_err_o}, {31'd0, e[32]});
            end
        end
    end

    task automatic do_req(input logic [15:0] addr, input logic [31:0] wdata, input logic we,
                          input int delay, input logic [31:0] cdata,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_stb, input int clr_at, input int hold);
        int n;
        int lat;
        bit seen;
        int acks0;
        sb_q.push_back({exp_err, exp_data});
        @(posedge clk); #1;
        core_delay = delay;
        core_data  = cdata;
        stb_cnt    = 0;
        dbg_addr_i = addr;
        dbg_data_i = wdata;
        dbg_we_i   = we;
        dbg_stb_i  = 1'b1;
        n     = cyc;
        acks0 = ack_total;
        seen  = 1'b0;
        lat   = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            err_clr_i = (clr_at >= 0) && (cyc - n == clr_at);
            if (dbg_ack_o) begin
                seen = 1'b1;
                lat  = cyc - n;
            end
        end
        err_clr_i = 1'b0;
        if (!seen) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        dbg_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("latency", lat, exp_lat);
        chk("stb_cycles", stb_cnt, exp_stb);
        chk("single_ack", ack_total - acks0, 32'd1);
        chk("spr_addr", {16'd0, spr_addr_o}, {16'd0, addr});
        chk("spr_we", {31'd0, spr_we_o}, {31'd0, we});
        chk("spr_data", spr_data_o, wdata);
    endtask

    initial begin
        int acks0;
        #3;
        chk("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rst_data", dbg_data_o, 32'd0);
        chk("rst_stb", {31'd0, spr_stb_o}, 32'd0);
        chk("rst_addr", {16'd0, spr_addr_o}, 32'd0);
        chk("rst_we", {31'd0, spr_we_o}, 32'd0);
        chk("rst_err", {31'd0, timeout_err_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Single-cycle core ack read.
        do_req(16'h2010, 32'h0, 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1, -1, 0);
        // Write, core acks in 6th stb cycle; read data register unchanged.
        do_req(16'h3000, 32'hA5A5_A5A5, 1'b1, 5, 32'h0BAD_0BAD, 32'h1234_5678, 1'b0, 7, 6, -1, 0);
        // Read timeout.
        do_req(16'h0040, 32'h0, 1'b0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, T + 1, T, -1, 0);
        repeat (5) @(posedge clk);
        #1 chk("err_sticky", {31'd0, timeout_err_o}, 32'd1);
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        chk("err_cleared", {31'd0, timeout_err_o}, 32'd0);

        // Ack in the same cycle the counter reaches TIMEOUT-1: ack wins.
        do_req(16'h0041, 32'h0, 1'b0, T - 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, T + 1, T, -1, 0);
        chk("ack_wins_err", {31'd0, timeout_err_o}, 32'd0);

        // Write timeout with a coincident clear: set wins, data unchanged.
        do_req(16'h0042, 32'h7777_0000, 1'b1, -1, 32'h0, 32'hCAFE_F00D, 1'b1, T + 1, T, T, 0);
        chk("set_beats_clr", {31'd0, timeout_err_o}, 32'd1);
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;

        // Strobe held 3 cycles past ack: no re-issue.
        do_req(16'h0050, 32'h0, 1'b0, 2, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, 4, 3, -1, 3);

        // Reset asserted mid-REQ: outputs clear immediately, no ack.
        @(posedge clk); #1;
        core_delay = -1;
        stb_cnt    = 0;
        dbg_addr_i = 16'h0100;
        dbg_we_i   = 1'b0;
        dbg_stb_i  = 1'b1;
        acks0      = ack_total;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_stb", {31'd0, spr_stb_o}, 32'd0);
        chk("mid_rst_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("mid_rst_data", dbg_data_o, 32'd0);
        chk("mid_rst_addr", {16'd0, spr_addr_o}, 32'd0);
        dbg_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (T + 4) @(posedge clk);
        #1 chk("mid_rst_no_ack", ack_total - acks0, 32'd0);

        // Recovery after reset.
        do_req(16'h0200, 32'h0, 1'b0, 1, 32'h1111_2222, 32'h1111_2222, 1'b0, 3, 2, -1, 0);

`ifdef ADBG_SPR_STALL_GATE_EN
        // Strobe withheld until the core stalls.
        sb_q.push_back({1'b0, 32'h5A5A_0001});
        @(posedge clk); #1;
        cpu_stalled_i = 1'b0;
        core_delay = 0;
        core_data  = 32'h5A5A_0001;
        stb_cnt    = 0;
        dbg_addr_i = 16'h0300;
        dbg_we_i   = 1'b0;
        dbg_stb_i  = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("stall_no_stb", stb_cnt, 32'd0);
        cpu_stalled_i = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (dbg_ack_o) seen = 1'b1;
            end
            if (!seen) chk("stall_ack_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        dbg_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("stall_stb_cycles", stb_cnt, 32'd1);
`endif

        repeat (5) @(posedge clk);
        #1 chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
